// File: rtl/blake2_arb_pkg.sv
// Shared types and default sizes for the Blake2 engine arbiter.
//   arb_state_t       : arbiter FSM states (IDLE, BUSY, HOLD)
//   DEF_NUM_REQ       : default number of requesters
//   DEF_BLOCK_WIDTH   : default engine block width, bits
//   DEF_DATA_LENGTH   : default message length field width, bits
//   DEF_TIMEOUT_CYCLES: default HOLD watchdog limit (BLAKE2_ARB_TIMEOUT_EN builds)
package blake2_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      HOLD = 2'd2
   } arb_state_t;

   localparam int DEF_NUM_REQ        = 4;
   localparam int DEF_BLOCK_WIDTH    = 1024;
   localparam int DEF_DATA_LENGTH    = 64;
   localparam int DEF_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/blake2_engine_arbiter_rr.sv
// Combinational round-robin picker.
// Returns the first set bit of the eligible mask found by scanning upward
// from rr_ptr and wrapping modulo NUM_REQ.
//   eligible    in  NUM_REQ          candidates
//   rr_ptr      in  $clog2(NUM_REQ)  highest-priority index
//   grant_valid out 1                at least one candidate
//   grant_id    out $clog2(NUM_REQ)  chosen index (0 when grant_valid=0)
module rr_arbiter
   import blake2_arb_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ
) (
   input  logic [NUM_REQ-1:0]         eligible,
   input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
   output logic                       grant_valid,
   output logic [$clog2(NUM_REQ)-1:0] grant_id
);

   localparam int ID_W = $clog2(NUM_REQ);

   logic [ID_W:0]   sum;
   logic [ID_W-1:0] idx;

   always_comb begin
      grant_valid = 1'b0;
      grant_id    = '0;
      sum         = '0;
      idx         = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         // One extra bit so the wrap works for non-power-of-two NUM_REQ.
         sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
         if (sum >= (ID_W+1)'(NUM_REQ)) begin
            sum = sum - (ID_W+1)'(NUM_REQ);
         end
         idx = sum[ID_W-1:0];
         if (!grant_valid && eligible[idx]) begin
            grant_valid = 1'b1;
            grant_id    = idx;
         end
      end
   end

endmodule

// File: rtl/blake2_engine_arbiter.sv
// Shares one Blake2 hash engine between NUM_REQ block-level requesters.
// The engine is locked to one requester from its first block through its
// digest; new message owners are chosen round-robin. All outputs registered.
// Optional feature macro: BLAKE2_ARB_TIMEOUT_EN (HOLD watchdog that revokes
// a silent owner after TIMEOUT_CYCLES consecutive HOLD cycles).
// Ports:
//   clk, reset_n                       clock, async active-low reset
//   req_valid/req_first/req_last       per-requester block handshake
//   req_block, req_length              per-requester slices
//   req_ready, done, abort             per-requester 1-cycle pulses
//   owner_id, busy                     current lock holder
//   init, next, final_block            engine command pulses
//   block, data_length                 engine data (hold until next issue)
//   hash_ready, digest_valid           engine status
module blake2_engine_arbiter
   import blake2_arb_pkg::*;
#(
   parameter int NUM_REQ        = DEF_NUM_REQ,
   parameter int BLOCK_WIDTH    = DEF_BLOCK_WIDTH,
   parameter int DATA_LENGTH    = DEF_DATA_LENGTH,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic [NUM_REQ-1:0]             req_valid,
   input  logic [NUM_REQ-1:0]             req_first,
   input  logic [NUM_REQ-1:0]             req_last,
   input  logic [NUM_REQ*BLOCK_WIDTH-1:0] req_block,
   input  logic [NUM_REQ*DATA_LENGTH-1:0] req_length,
   output logic [NUM_REQ-1:0]             req_ready,
   output logic [NUM_REQ-1:0]             done,
   output logic [NUM_REQ-1:0]             abort,
   output logic [$clog2(NUM_REQ)-1:0]     owner_id,
   output logic                           busy,
   output logic                           init,
   output logic                           next,
   output logic                           final_block,
   output logic [BLOCK_WIDTH-1:0]         block,
   output logic [DATA_LENGTH-1:0]         data_length,
   input  logic                           hash_ready,
   input  logic                           digest_valid
);

   localparam int ID_W = $clog2(NUM_REQ);

   arb_state_t              state, state_nx;
   logic [ID_W-1:0]         rr_ptr, rr_ptr_nx, owner_nx, wrap_ptr;
   logic                    last_flag, last_flag_nx;
   logic                    saw_low, saw_low_nx;
   logic                    busy_nx, init_nx, next_nx, final_nx;
   logic [NUM_REQ-1:0]      req_ready_nx, done_nx;
   logic [BLOCK_WIDTH-1:0]  block_nx;
   logic [DATA_LENGTH-1:0]  len_nx;
   logic                    grant_valid;
   logic [ID_W-1:0]         grant_id;
   logic [BLOCK_WIDTH-1:0]  blk_arr [NUM_REQ];
   logic [DATA_LENGTH-1:0]  len_arr [NUM_REQ];

`ifdef BLAKE2_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0]        hold_cnt, hold_cnt_nx;
   logic [NUM_REQ-1:0]      abort_nx;
`else
   assign abort = '0;
`endif

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
      assign blk_arr[g] = req_block[g*BLOCK_WIDTH +: BLOCK_WIDTH];
      assign len_arr[g] = req_length[g*DATA_LENGTH +: DATA_LENGTH];
   end

   // Only message starts compete; continuation blocks are taken in HOLD.
   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
      .eligible    (req_valid & req_first),
      .rr_ptr      (rr_ptr),
      .grant_valid (grant_valid),
      .grant_id    (grant_id)
   );

   assign wrap_ptr = (owner_id == ID_W'(NUM_REQ - 1)) ? '0 : owner_id + 1'b1;

   always_comb begin
      state_nx     = state;
      rr_ptr_nx    = rr_ptr;
      owner_nx     = owner_id;
      last_flag_nx = last_flag;
      saw_low_nx   = saw_low;
      busy_nx      = busy;
      init_nx      = 1'b0;
      next_nx      = 1'b0;
      final_nx     = 1'b0;
      req_ready_nx = '0;
      done_nx      = '0;
      block_nx     = block;
      len_nx       = data_length;
`ifdef BLAKE2_ARB_TIMEOUT_EN
      hold_cnt_nx  = hold_cnt;
      abort_nx     = '0;
`endif
      unique case (state)
         IDLE: begin
            if (hash_ready && grant_valid) begin
               state_nx     = BUSY;
               owner_nx     = grant_id;
               busy_nx      = 1'b1;
               init_nx      = 1'b1;
               req_ready_nx = NUM_REQ'(1) << grant_id;
               last_flag_nx = req_last[grant_id];
               final_nx     = req_last[grant_id];
               block_nx     = blk_arr[grant_id];
               len_nx       = len_arr[grant_id];
               saw_low_nx   = 1'b0;
            end
         end
         BUSY: begin
            if (last_flag) begin
               if (digest_valid) begin
                  state_nx  = IDLE;
                  done_nx   = NUM_REQ'(1) << owner_id;
                  busy_nx   = 1'b0;
                  rr_ptr_nx = wrap_ptr;
               end
            end else if (!hash_ready) begin
               saw_low_nx = 1'b1;
            end else if (saw_low) begin
               // Engine dropped ready for this block and is ready again.
               state_nx = HOLD;
`ifdef BLAKE2_ARB_TIMEOUT_EN
               hold_cnt_nx = '0;
`endif
            end
         end
         HOLD: begin
            // req_first from the owner here is treated as a plain next block.
            if (req_valid[owner_id]) begin
               state_nx     = BUSY;
               next_nx      = 1'b1;
               req_ready_nx = NUM_REQ'(1) << owner_id;
               last_flag_nx = req_last[owner_id];
               final_nx     = req_last[owner_id];
               block_nx     = blk_arr[owner_id];
               len_nx       = len_arr[owner_id];
               saw_low_nx   = 1'b0;
            end
`ifdef BLAKE2_ARB_TIMEOUT_EN
            else if (hold_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               state_nx  = IDLE;
               abort_nx  = NUM_REQ'(1) << owner_id;
               busy_nx   = 1'b0;
               rr_ptr_nx = wrap_ptr;
            end else begin
               hold_cnt_nx = hold_cnt + 1'b1;
            end
`endif
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         rr_ptr      <= '0;
         owner_id    <= '0;
         last_flag   <= 1'b0;
         saw_low     <= 1'b0;
         busy        <= 1'b0;
         init        <= 1'b0;
         next        <= 1'b0;
         final_block <= 1'b0;
         req_ready   <= '0;
         done        <= '0;
         block       <= '0;
         data_length <= '0;
`ifdef BLAKE2_ARB_TIMEOUT_EN
         hold_cnt    <= '0;
         abort       <= '0;
`endif
      end else begin
         state       <= state_nx;
         rr_ptr      <= rr_ptr_nx;
         owner_id    <= owner_nx;
         last_flag   <= last_flag_nx;
         saw_low     <= saw_low_nx;
         busy        <= busy_nx;
         init        <= init_nx;
         next        <= next_nx;
         final_block <= final_nx;
         req_ready   <= req_ready_nx;
         done        <= done_nx;
         block       <= block_nx;
         data_length <= len_nx;
`ifdef BLAKE2_ARB_TIMEOUT_EN
         hold_cnt    <= hold_cnt_nx;
         abort       <= abort_nx;
`endif
      end
   end

endmodule
